// File: rtl/aes256_key_expander.sv
// Iterative AES-256 key schedule: emits round keys 0..14, one per valid/ready handshake,
// expanding on the fly from an 8-word sliding window instead of a stored 60-word schedule.
//
// state | meaning
// IDLE  | no schedule active; all outputs zero; waiting for key_load_in
// EMIT  | presenting round key r; the window advances by four words on each handshake

module aes256_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);
    // Entry 0 sits in the most significant byte so the table reads in FIPS-197 order.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s_o = SBOX[a_i];
endmodule

module aes256_key_expander #(
    parameter int NK__KEY_LENGTH           = 8,
    parameter int NR__ROUNDS               = 14,
    parameter int NB__BLOCK_LENGTH_IN_TEXT = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NK__KEY_LENGTH*32-1:0]             key_in,
    input  logic                                     key_load_in,
    output logic                                     key_busy_out,
    output logic [NB__BLOCK_LENGTH_IN_TEXT*32-1:0]   round_key_out,
    output logic [NB__BLOCK_LENGTH_IN_TEXT-1:0]      round_number_out,
    output logic                                     round_key_valid_out,
    input  logic                                     round_key_ready_in,
    output logic                                     last_round_key_out
);
    localparam int                                WW         = NK__KEY_LENGTH * 32;
    localparam logic [NB__BLOCK_LENGTH_IN_TEXT-1:0] LAST_ROUND = NB__BLOCK_LENGTH_IN_TEXT'(NR__ROUNDS);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                              state_q, state_d;
    logic [WW-1:0]                       w_q, w_d;
    logic [NB__BLOCK_LENGTH_IN_TEXT-1:0] r_q, r_d;

    logic [31:0] w7;
    logic [31:0] sub_in;
    logic [31:0] sub_out;
    logic [31:0] t;
    logic [7:0]  rcon;
    logic [31:0] n0, n1, n2, n3;
    logic        emit;

    // Even rounds take the RotWord+Rcon step, odd rounds the AES-256 plain SubWord step.
    assign w7     = w_q[31:0];
    assign sub_in = r_q[0] ? w7 : {w7[23:0], w7[31:24]};
    assign rcon   = r_q[0] ? 8'h00 : (8'h01 << r_q[3:1]);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes256_sbox u_sbox (
            .a_i (sub_in[8*i +: 8]),
            .s_o (sub_out[8*i +: 8])
        );
    end

    assign t  = sub_out ^ {rcon, 24'h0};
    assign n0 = w_q[255:224] ^ t;
    assign n1 = w_q[223:192] ^ n0;
    assign n2 = w_q[191:160] ^ n1;
    assign n3 = w_q[159:128] ^ n2;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        r_d     = r_q;
        unique case (state_q)
            IDLE: begin
                if (key_load_in) begin
                    w_d     = key_in;
                    r_d     = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (round_key_ready_in) begin
                    if (r_q == LAST_ROUND) begin
                        // Drop the key material once the schedule has been consumed.
                        w_d     = '0;
                        r_d     = '0;
                        state_d = IDLE;
                    end else begin
                        w_d = {w_q[127:0], n0, n1, n2, n3};
                        r_d = r_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            r_q     <= r_d;
        end
    end

    assign emit                = (state_q == EMIT);
    assign round_key_valid_out = emit;
    assign key_busy_out        = emit;
    assign round_key_out       = emit ? w_q[WW-1:WW/2] : '0;
    assign round_number_out    = emit ? r_q : '0;
    assign last_round_key_out  = emit && (r_q == LAST_ROUND);
endmodule

// File: tb/tb_aes256_key_expander.sv
// Directed bench for aes256_key_expander using FIPS-197 C.3 round keys and the A.3 cipher key.

module tb_aes256_key_expander;
    logic         clk;
    logic         rst;
    logic [255:0] key_in;
    logic         key_load_in;
    logic         key_busy_out;
    logic [127:0] round_key_out;
    logic [3:0]   round_number_out;
    logic         round_key_valid_out;
    logic         round_key_ready_in;
    logic         last_round_key_out;

    aes256_key_expander dut (
        .clk                 (clk),
        .rst                 (rst),
        .key_in              (key_in),
        .key_load_in         (key_load_in),
        .key_busy_out        (key_busy_out),
        .round_key_out       (round_key_out),
        .round_number_out    (round_number_out),
        .round_key_valid_out (round_key_valid_out),
        .round_key_ready_in  (round_key_ready_in),
        .last_round_key_out  (last_round_key_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         last;
    } vec_t;

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    vec_t c3 [15];
    int   tests;
    int   fails;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " valid"}, {127'b0, round_key_valid_out}, 128'd0);
        chk({name, " busy"},  {127'b0, key_busy_out},        128'd0);
        chk({name, " last"},  {127'b0, last_round_key_out},  128'd0);
        chk({name, " key"},   round_key_out,                 128'd0);
        chk({name, " rnum"},  {124'b0, round_number_out},    128'd0);
    endtask

    // Called at a negedge; leaves the bench at the negedge where round key 0 should be visible.
    task automatic do_load(input logic [255:0] k);
        key_in      = k;
        key_load_in = 1'b1;
        @(negedge clk);
        key_load_in = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        round_key_ready_in = 1'b1;
        while (round_key_valid_out === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        round_key_ready_in = 1'b0;
        chk("drain ends idle", {127'b0, round_key_valid_out}, 128'd0);
    endtask

    // Walks the C.3 schedule; optionally random ready and a load pulse (key A.3) while at pulse_at.
    task automatic run_c3(input bit rand_ready, input int pulse_at, input string tag);
        int           idx;
        int           cyc;
        bit           stalled;
        logic [127:0] saved_key;
        logic [3:0]   saved_rn;
        logic         saved_last;
        idx     = 0;
        cyc     = 0;
        stalled = 1'b0;
        while (idx < 15 && cyc < 300) begin
            chk({tag, " valid"}, {127'b0, round_key_valid_out}, 128'd1);
            chk({tag, " busy"},  {127'b0, key_busy_out},        128'd1);
            chk({tag, " rnum"},  {124'b0, round_number_out},    {124'b0, c3[idx].rnd});
            chk({tag, " key"},   round_key_out,                 c3[idx].key);
            chk({tag, " last"},  {127'b0, last_round_key_out},  {127'b0, c3[idx].last});
            if (stalled) begin
                chk({tag, " hold key"},  round_key_out,              saved_key);
                chk({tag, " hold rnum"}, {124'b0, round_number_out}, {124'b0, saved_rn});
                chk({tag, " hold last"}, {127'b0, last_round_key_out}, {127'b0, saved_last});
            end
            round_key_ready_in = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == pulse_at) begin
                key_in      = KEY_A3;
                key_load_in = 1'b1;
            end else begin
                key_load_in = 1'b0;
            end
            saved_key  = round_key_out;
            saved_rn   = round_number_out;
            saved_last = last_round_key_out;
            stalled    = !round_key_ready_in;
            @(negedge clk);
            if (round_key_ready_in) idx++;
            cyc++;
        end
        key_load_in        = 1'b0;
        round_key_ready_in = 1'b0;
        chk({tag, " handshake count"}, 128'(idx), 128'd15);
        chk_idle({tag, " after r14"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        c3[0]  = '{4'd0,  128'h000102030405060708090a0b0c0d0e0f, 1'b0};
        c3[1]  = '{4'd1,  128'h101112131415161718191a1b1c1d1e1f, 1'b0};
        c3[2]  = '{4'd2,  128'ha573c29fa176c498a97fce93a572c09c, 1'b0};
        c3[3]  = '{4'd3,  128'h1651a8cd0244beda1a5da4c10640bade, 1'b0};
        c3[4]  = '{4'd4,  128'hae87dff00ff11b68a68ed5fb03fc1567, 1'b0};
        c3[5]  = '{4'd5,  128'h6de1f1486fa54f9275f8eb5373b8518d, 1'b0};
        c3[6]  = '{4'd6,  128'hc656827fc9a799176f294cec6cd5598b, 1'b0};
        c3[7]  = '{4'd7,  128'h3de23a75524775e727bf9eb45407cf39, 1'b0};
        c3[8]  = '{4'd8,  128'h0bdc905fc27b0948ad5245a4c1871c2f, 1'b0};
        c3[9]  = '{4'd9,  128'h45f5a66017b2d387300d4d33640a820a, 1'b0};
        c3[10] = '{4'd10, 128'h7ccff71cbeb4fe5413e6bbf0d261a7df, 1'b0};
        c3[11] = '{4'd11, 128'hf01afafee7a82979d7a5644ab3afe640, 1'b0};
        c3[12] = '{4'd12, 128'h2541fe719bf500258813bbd55a721c0a, 1'b0};
        c3[13] = '{4'd13, 128'h4e5a6699a9f24fe07e572baacdf8cdea, 1'b0};
        c3[14] = '{4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b1};

        // Reset held three cycles with a load request pending.
        rst                = 1'b1;
        key_load_in        = 1'b1;
        key_in             = KEY_C3;
        round_key_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("reset hold");
        end
        rst         = 1'b0;
        key_load_in = 1'b0;
        @(negedge clk);
        chk_idle("post reset idle");

        // Ready held high: load latency then 15 back-to-back keys.
        do_load(KEY_C3);
        chk("load latency valid", {127'b0, round_key_valid_out}, 128'd1);
        chk("load latency busy",  {127'b0, key_busy_out},        128'd1);
        run_c3(1'b0, -1, "stream");

        // Random backpressure.
        do_load(KEY_C3);
        run_c3(1'b1, -1, "backpressure");

        // Load pulse while busy at r=5, then a reload once idle.
        do_load(KEY_C3);
        run_c3(1'b0, 5, "load busy");
        do_load(KEY_A3);
        chk("reload r0", round_key_out, 128'h603deb1015ca71be2b73aef0857d7781);
        chk("reload rnum0", {124'b0, round_number_out}, 128'd0);
        round_key_ready_in = 1'b1;
        @(negedge clk);
        chk("reload r1", round_key_out, 128'h1f352c073b6108d72d9810a30914dff4);
        chk("reload rnum1", {124'b0, round_number_out}, 128'd1);
        drain();

        // Reset at r=7 with ready low.
        do_load(KEY_C3);
        round_key_ready_in = 1'b1;
        for (int n = 0; n < 30 && round_number_out != 4'd7; n++) @(negedge clk);
        round_key_ready_in = 1'b0;
        chk("mid rnum7", {124'b0, round_number_out}, 128'd7);
        @(negedge clk);
        chk("mid stall key", round_key_out, c3[7].key);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_idle("mid reset");
        @(negedge clk);
        chk_idle("mid reset stays idle");
        do_load(KEY_C3);
        chk("restart rnum", {124'b0, round_number_out}, 128'd0);
        chk("restart key", round_key_out, c3[0].key);
        drain();

        // Load in the same cycle as the r14 handshake is ignored; the next cycle's load is taken.
        do_load(KEY_C3);
        run_c3(1'b0, 14, "simultaneous");
        do_load(KEY_A3);
        chk("late load valid", {127'b0, round_key_valid_out}, 128'd1);
        chk("late load key", round_key_out, 128'h603deb1015ca71be2b73aef0857d7781);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes256_key_expander.md
# aes256_key_expander

Iterative AES-256 key schedule generator (FIPS-197 §5.2) that produces the 15 round keys (rounds 0..14) one per handshake, in order, for the AddRoundKey stage that consumes each round's SubBytes/ShiftRows/MixColumns output. It sits beside the round datapath and supplies the key XORed after every round. Keys are expanded on the fly from an 8-word sliding window, with no 60-word key RAM.

## Interface
- NK__KEY_LENGTH, 8, key length in 32-bit words (AES-256 only).
- NR__ROUNDS, 14, index of the last round key.
- NB__BLOCK_LENGTH_IN_TEXT, 4, words per round key; also the width of the round number.

- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- key_in  input  NK__KEY_LENGTH*32 (256)  cipher key; word 0 is bits [255:224], big-endian bytes.
- key_load_in  input  1  load request; sampled only while key_busy_out=0.
- key_busy_out  output  1  high from the cycle after an accepted load until the round-14 handshake completes.
- round_key_out  output  NB__BLOCK_LENGTH_IN_TEXT*32 (128)  current round key w[4r..4r+3]; w[4r] is in [127:96].
- round_number_out  output  NB__BLOCK_LENGTH_IN_TEXT (4)  r, the round index of round_key_out.
- round_key_valid_out  output  1  round_key_out and round_number_out are valid.
- round_key_ready_in  input  1  consumer accepts the key this cycle.
- last_round_key_out  output  1  high while valid and r == NR__ROUNDS.

## Operation
- **FSM states:** IDLE and EMIT.
- **IDLE:**
  - All outputs are 0.
  - key_load_in=1 loads the window register with W = key_in and sets r = 0.
  - The FSM moves to EMIT.
- **EMIT:**
  - round_key_valid_out = 1.
  - round_key_out = W[255:128].
  - The handshake is valid && ready.
- **On a handshake with r < 14:**
  - W <= {W[127:0], n0, n1, n2, n3} and r <= r+1.
  - The new words are n0 = W0^t, n1 = W1^n0, n2 = W2^n1, n3 = W3^n2, where W0..W3 are the four words of W[255:128].
  - r even: t = SubWord(RotWord(W7)) ^ {Rcon[r/2+1], 24'h0}.
  - r odd: t = SubWord(W7), with no Rcon.
  - W7 is W[31:0].
  - Rcon[1..7] = 01, 02, 04, 08, 10, 20, 40.
- **On a handshake with r == 14:** go to IDLE. Valid, busy and last drop the next cycle; round_key_out and round_number_out return to 0.
- **Datapath:** SubWord applies the FIPS-197 S-box to each of 4 bytes. Four S-box instances plus an XOR chain of 4 words, all combinational within one cycle.
- **No stall:** while ready stays high, keys stream 1 per cycle.

## Timing
- **Reset:**
  - rst=1 forces IDLE, W=0 and r=0.
  - round_key_out=0, round_number_out=0, valid=0, busy=0, last=0 on the cycle after rst is sampled.
  - rst overrides a load or handshake in the same cycle.
- **Load latency:** key_load_in sampled high in cycle T (IDLE) gives valid=1, busy=1, r=0 and round key 0 = key_in[255:128] in cycle T+1.
- **Hold while stalled:** while valid=1 and ready=0, round_key_out, round_number_out and last hold stable for any number of cycles.
- **Minimum sequence time:** 15 handshakes. With ready held high, the fastest load-to-IDLE time is 16 cycles.
- **Load while busy:** key_load_in while busy=1 is ignored. This includes the cycle of the round-14 handshake. The earliest new load is accepted the first cycle busy=0.
- **Reset mid-sequence:** the partially emitted schedule is discarded. A fresh load is required.
- **Width rules:**
  - r is 4 bits and never exceeds 14.
  - Rcon is indexed by r[3:1]+1, so r=12 yields 40.
  - No words beyond w[59] are ever exposed.

## Test plan
- **FIPS-197 C.3 key:** key 000102…1e1f, ready held high.
  - r0 = 000102030405060708090a0b0c0d0e0f.
  - r1 = 101112131415161718191a1b1c1d1e1f.
  - r2 = a573c29fa176c498a97fce93a572c09c.
  - r3 = 1651a8cd0244beda1a5da4c10640bade.
  - r14 = 24fc79ccbf0979e9371ac23c6d68de36.
  - last=1 only with r14; valid falls after 15 consecutive cycles.
- **Random backpressure:** same key with ready toggling randomly.
  - Identical key sequence to the first test.
  - Outputs stable during every stall.
  - Exactly 15 handshakes, round numbers 0..14 contiguous.
- **Load while busy:** pulse key_load_in with key 603deb10…0914dff4 at r=5.
  - The running sequence completes with C.3 keys unchanged.
  - A reload after busy=0 gives r0 = 603deb1015ca71be2b73aef0857d7781.
- **Reset mid-sequence:** rst at r=7, ready low.
  - All outputs 0 the next cycle, state IDLE.
  - A subsequent load restarts at r=0.
- **Simultaneous events:** key_load_in high in the same cycle as the r=14 handshake.
  - The load is ignored and valid falls.
  - A load one cycle later is accepted and valid returns the following cycle.
- **Reset value check:** rst held 3 cycles with key_load_in=1.
  - valid, busy and last remain 0.
  - round_key_out and round_number_out remain 0.
